// File: rtl/cpu0_mem_resp.sv
// CPU0 byte-addressable memory responder: IDLE/WAIT/RESP handshake, big-endian words.
// Optional macro CPU0_MEM_ALIGN_CHK_EN turns misaligned word accesses into err responses.
module cpu0_mem_resp #(
  parameter int AW   = 10,
  parameter int WAIT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << AW;
  localparam logic [3:0] CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  // Handshake: req is sampled only in IDLE; the accept edge latches the request,
  // busy stays high through the single ack cycle, and req is ignored until IDLE.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

  state_t state, state_next;
  logic [3:0]    cnt;
  logic          lat_we, lat_size;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [7:0]    mem [DEPTH];

  logic          cur_we, cur_size, commit, misalign;
  logic [AW-1:0] cur_addr, a0, a1, a2, a3;
  logic [31:0]   cur_wdata, rd_val;
  logic          unused_hi;

  assign unused_hi = ^addr[31:AW];

  // With WAIT=0 the commit edge is the accept edge, so fields come straight from the inputs.
  assign cur_we    = (state == ST_IDLE) ? we            : lat_we;
  assign cur_size  = (state == ST_IDLE) ? size          : lat_size;
  assign cur_addr  = (state == ST_IDLE) ? addr[AW-1:0]  : lat_addr;
  assign cur_wdata = (state == ST_IDLE) ? wdata         : lat_wdata;

  assign a0 = cur_addr;
  assign a1 = cur_addr + AW'(1);
  assign a2 = cur_addr + AW'(2);
  assign a3 = cur_addr + AW'(3);

`ifdef CPU0_MEM_ALIGN_CHK_EN
  assign misalign = cur_size & (cur_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign commit = reset_n && (state != ST_RESP) && (state_next == ST_RESP);
  assign rd_val = cur_size ? {mem[a0], mem[a1], mem[a2], mem[a3]} : {24'b0, mem[a0]};

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req) state_next = (WAIT == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ack       = (state == ST_RESP);
    busy      = (state != ST_IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_size  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      rdata     <= 32'd0;
    end else begin
      if (state == ST_IDLE && req) begin
        cnt       <= CNT_INIT;
        lat_we    <= we;
        lat_size  <= size;
        lat_addr  <= addr[AW-1:0];
        lat_wdata <= wdata;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) rdata <= (cur_we || misalign) ? 32'd0 : rd_val;
    end
  end

  // Storage has no reset so contents survive reset_n.
  always_ff @(posedge clock) begin
    if (commit && cur_we && !misalign) begin
      if (cur_size) begin
        mem[a0] <= cur_wdata[31:24];
        mem[a1] <= cur_wdata[23:16];
        mem[a2] <= cur_wdata[15:8];
        mem[a3] <= cur_wdata[7:0];
      end else begin
        mem[a0] <= cur_wdata[7:0];
      end
    end
  end

`ifdef CPU0_MEM_ALIGN_CHK_EN
  logic err_q;
  always_ff @(posedge clock) begin
    if (!reset_n)    err_q <= 1'b0;
    else if (commit) err_q <= misalign;
  end
  assign err = (state == ST_RESP) & err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu0_mem_resp.sv
// Randomized self-checking bench for cpu0_mem_resp against a byte-array memory model.
module tb_cpu0_mem_resp;

  localparam int AW        = 10;
  localparam int WAIT      = 2;
  localparam int MEM_BYTES = 1 << AW;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, size = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        ack, err, busy;
  logic [31:0] rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  cpu0_mem_resp #(.AW(AW), .WAIT(WAIT)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .size(size),
    .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .err(err),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: flat byte array, big-endian words, offsets wrap modulo memory size.
  function automatic void model_access(input logic w, input logic sz, input logic [31:0] a,
                                       input logic [31:0] d, output logic [31:0] rd,
                                       output logic e);
    int base;
    bit mis;
    base = int'(a % 32'(MEM_BYTES));
    mis  = 1'b0;
`ifdef CPU0_MEM_ALIGN_CHK_EN
    mis = sz && (a % 4 != 0);
`endif
    e  = mis;
    rd = 32'd0;
    if (mis) return;
    if (w) begin
      if (sz) for (int k = 0; k < 4; k++) ref_mem[(base + k) % MEM_BYTES] = 8'(d >> (8 * (3 - k)));
      else ref_mem[base] = d[7:0];
    end else begin
      if (sz) for (int k = 0; k < 4; k++) rd = (rd << 8) | 32'(ref_mem[(base + k) % MEM_BYTES]);
      else rd = 32'(ref_mem[base]);
    end
  endfunction

  function automatic logic [31:0] model_word(input int base);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < 4; k++) v = (v << 8) | 32'(ref_mem[(base + k) % MEM_BYTES]);
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    reset_n = 1'b1;
  endtask

  task automatic do_access(input logic w, input logic sz, input logic [31:0] a,
                           input logic [31:0] d, input string tag,
                           output logic [31:0] rd, output logic e);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          cyc;
    bit          got;
    model_access(w, sz, a, d, exp_rd, exp_err);
    exp_q.push_back(exp_rd);
    @(negedge clock);
    req = 1'b1; we = w; size = sz; addr = a; wdata = d;
    @(posedge clock);
    #1;
    req = 1'b0; we = 1'($urandom); size = 1'($urandom); addr = $urandom; wdata = $urandom;
    @(negedge clock);
    check({tag, "_busy"}, busy, 1);
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 64) begin
      if (ack) begin
        got = 1'b1;
        req = 1'b0;
      end else begin
        req = 1'($urandom);
        @(posedge clock);
        cyc++;
        @(negedge clock);
      end
    end
    req = 1'b0;
    check({tag, "_ack_seen"}, got, 1);
    check({tag, "_latency"}, cyc, WAIT + 1);
    rd = rdata;
    e  = err;
    check({tag, "_rdata"}, rdata, exp_q.pop_front());
    check({tag, "_err"}, err, exp_err);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_ack_drop"}, ack, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_rdata_hold"}, rdata, rd);
    last_rd = rd;
  endtask

  initial begin
    logic [31:0] rd, prior;
    logic        e;
    int          ack_cnt;

    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    apply_reset();

    for (int i = 0; i < MEM_BYTES / 4; i++) do_access(1'b1, 1'b1, 32'(i * 4), $urandom, "fill", rd, e);

    do_access(1'b1, 1'b1, 32'h010, 32'h11223344, "w010", rd, e);
    check("w010_zero", rd, 32'd0);
    do_access(1'b0, 1'b1, 32'h010, 32'd0, "r010", rd, e);
    check("r010_val", rd, 32'h11223344);
    do_access(1'b0, 1'b0, 32'h012, 32'd0, "rb012", rd, e);
    check("rb012_val", rd, 32'h00000033);
    do_access(1'b1, 1'b0, 32'h013, 32'hFFFFFFAB, "wb013", rd, e);
    do_access(1'b0, 1'b1, 32'h010, 32'd0, "r010b", rd, e);
    check("r010b_val", rd, 32'h112233AB);
    do_access(1'b0, 1'b1, 32'h410, 32'd0, "r410", rd, e);
    check("alias410", rd, 32'h112233AB);

    do_access(1'b1, 1'b1, 32'h3FE, 32'hDEADBEEF, "w3fe", rd, e);
`ifndef CPU0_MEM_ALIGN_CHK_EN
    do_access(1'b0, 1'b0, 32'h3FE, 32'd0, "rb3fe", rd, e);
    check("wrap_3fe", rd, 32'hDE);
    do_access(1'b0, 1'b0, 32'h3FF, 32'd0, "rb3ff", rd, e);
    check("wrap_3ff", rd, 32'hAD);
    do_access(1'b0, 1'b0, 32'h000, 32'd0, "rb000", rd, e);
    check("wrap_000", rd, 32'hBE);
    do_access(1'b0, 1'b0, 32'h001, 32'd0, "rb001", rd, e);
    check("wrap_001", rd, 32'hEF);
    check("wrap_err", e, 0);
`endif

    // Continuous word reads of 0x010: acks every WAIT+2 cycles.
    ack_cnt = 0;
    @(negedge clock);
    req = 1'b1; we = 1'b0; size = 1'b1; addr = 32'h010;
    @(posedge clock);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      check($sformatf("cont_ack_%0d", k), ack, (k % 4 == 3) ? 1 : 0);
      check($sformatf("cont_busy_%0d", k), busy, (k % 4 == 0) ? 0 : 1);
      if (ack) begin
        ack_cnt++;
        check($sformatf("cont_rdata_%0d", k), rdata, model_word(16));
      end
      if (k == 12) req = 1'b0;
      @(posedge clock);
    end
    check("cont_ack_count", ack_cnt, 3);

    // Reset in the second WAIT cycle aborts a write to 0x020.
    prior = model_word(32);
    @(negedge clock);
    req = 1'b1; we = 1'b1; size = 1'b1; addr = 32'h020; wdata = 32'h55555555;
    @(posedge clock);
    #1 req = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_rdata", rdata, 0);
    ack_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (ack) ack_cnt++;
      @(negedge clock);
    end
    check("abort_no_ack", ack_cnt, 0);
    do_access(1'b0, 1'b1, 32'h020, 32'd0, "r020", rd, e);
    check("abort_prior", rd, prior);

    prior = model_word(32);
    do_access(1'b1, 1'b1, 32'h021, $urandom, "w021", rd, e);
`ifdef CPU0_MEM_ALIGN_CHK_EN
    check("w021_err", e, 1);
    do_access(1'b0, 1'b1, 32'h020, 32'd0, "r020b", rd, e);
    check("r020b_unchanged", rd, prior);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(1020, 1023)) : $urandom;
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, "rand", rd, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu0_mem_resp.md
CPU0_MEM_RESP -- requirements
Module: cpu0_mem_resp

Interface
REQ-001 Parameter AW, default 10, byte-address width; storage is 2^AW bytes.
REQ-002 Parameter WAIT, default 2, wait-state cycles inserted before each response (0..15).
REQ-003 clock  input  1  sole clock; all logic on posedge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  1  access request from the CPU0 load/store/fetch side.
REQ-006 we  input  1  1 = write, 0 = read.
REQ-007 size  input  1  0 = byte, 1 = 32-bit word.
REQ-008 addr  input  32  byte address; only addr[AW-1:0] used.
REQ-009 wdata  input  32  write data; byte writes use wdata[7:0].
REQ-010 ack  output  1  one-cycle completion pulse.
REQ-011 rdata  output  32  read data, valid while ack=1.
REQ-012 err  output  1  error flag, meaningful only while ack=1.
REQ-013 busy  output  1  high from the accept edge through the ack cycle.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 IDLE: req=1 at a posedge SHALL latch addr/we/size/wdata, set busy, and enter WAIT with counter=WAIT-1, or enter RESP directly if WAIT=0.
REQ-016 WAIT: the counter SHALL decrement each cycle; at counter=0 the FSM SHALL enter RESP on the next edge.
REQ-017 RESP: ack=1 for exactly one cycle, then IDLE; busy SHALL clear on that same edge.
REQ-018 Latency: ack SHALL rise WAIT+1 cycles after the accept edge; continuous req yields one access every WAIT+2 cycles.
REQ-019 req SHALL be ignored in WAIT and RESP; latched fields are immune to input changes after accept.
REQ-020 Byte order is big-endian: a word at address a SHALL map m[a]->[31:24], m[a+1]->[23:16], m[a+2]->[15:8], m[a+3]->[7:0].
REQ-021 Byte offsets a+1..a+3 SHALL wrap modulo 2^AW; addr bits at and above AW SHALL be ignored.
REQ-022 Byte read: rdata = {24'b0, m[a]}. Word read: rdata = the four bytes per REQ-020.
REQ-023 Writes SHALL commit to storage on the edge that enters RESP; a write's rdata SHALL be 0.
REQ-024 rdata SHALL hold its last value between acks.
REQ-025 Storage SHALL support one access per transaction only; no simultaneous read and write.

Reset
REQ-026 With reset_n=0 at a posedge: state=IDLE, counter=0, ack=0, err=0, busy=0, rdata=0.
REQ-027 Reset during WAIT SHALL abort the access with no ack and no storage write.
REQ-028 Storage contents SHALL NOT be cleared by reset.
REQ-029 reset_n SHALL take priority over req on the same edge.

Configuration
REQ-030 Macro CPU0_MEM_ALIGN_CHK_EN defined: a word access with addr[1:0]!=0 SHALL complete with normal latency, ack=1, err=1, rdata=0, and no storage write.
REQ-031 Macro CPU0_MEM_ALIGN_CHK_EN undefined: misaligned word accesses SHALL be performed bytewise per REQ-020/021, and err SHALL be tied 0.

Verification
REQ-032 All scenarios use WAIT=2 and AW=10. Reset, then word write 0x11223344 to 0x010, then word read 0x010 -> each ack arrives 3 cycles after accept; rdata=0x11223344.
REQ-033 After REQ-032, byte read 0x012 -> rdata=0x00000033; byte write 0xAB to 0x013, then word read 0x010 -> rdata=0x112233AB.
REQ-034 Word write 0xDEADBEEF to 0x3FE -> byte reads 0x3FE=0xDE, 0x3FF=0xAD, 0x000=0xBE, 0x001=0xEF (err=0, CPU0_MEM_ALIGN_CHK_EN undefined); address 0x410 aliases to 0x010.
REQ-035 Hold req=1 for 12 cycles of word reads -> exactly 3 acks, at cycles 3, 7 and 11 after the first accept; busy low only in the idle cycles between accesses.
REQ-036 Word write 0x55555555 to 0x020, pulse reset_n low in the second WAIT cycle -> no ack; a subsequent read of 0x020 returns the prior contents.
REQ-037 With CPU0_MEM_ALIGN_CHK_EN defined, word write to 0x021 -> ack with err=1; a read of 0x020 is unchanged.
